ad9361_cfg_seq: RTL and testbench

Configuration sequencer and SPI arbiter for the AD9361. It walks an external init table (writes, calibration polls, delays) and drives the existing AD9361 SPI driver through its request/busy handshake. After init completes, it hands the driver to a runtime host port for single register reads and writes. It sits between the radio control logic and the SPI driver, and is the only master of that driver.

---
 rtl/ad9361_cfg_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_ad9361_cfg_seq.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_cfg_seq.sv
// ad9361_cfg_seq: AD9361 configuration sequencer and SPI arbiter.
// It walks an external init table of WRITE / POLL / DELAY / END entries and
// issues each access to the SPI driver over its request/busy handshake. When
// it is not running the table, it serves single register reads and writes from
// a runtime host port. It is the only master of the SPI driver.
//
// Ports:
//   i_sys_clk, i_sys_rst      clock, synchronous active-high reset
//   i_start                   pulse: run the init table from entry 0
//   o_rom_addr, i_rom_data    table port; data valid 1 cycle after address
//   o_spi_*, i_spi_*          SPI driver request/busy/read-data handshake
//   i_host_*, o_host_*        runtime host access (req held until ack)
//   o_init_busy/done/err      table status; done/err sticky until next start
//   o_err_idx                 entry index of a timed-out POLL
module ad9361_cfg_seq #(
  parameter int unsigned ROM_AW     = 9,
  parameter int unsigned CLK_PER_US = 20,
  parameter int unsigned POLL_MAX   = 1023
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [19:0]       i_rom_data,
  output logic [9:0]        o_spi_addr,
  output logic [7:0]        o_spi_wdata,
  output logic              o_spi_wr_rdn,
  output logic              o_spi_en,
  input  logic              i_spi_busy,
  input  logic [7:0]        i_spi_rdata,
  input  logic              i_spi_rdata_en,
  input  logic              i_host_req,
  input  logic              i_host_wr_rdn,
  input  logic [9:0]        i_host_addr,
  input  logic [7:0]        i_host_wdata,
  output logic              o_host_ack,
  output logic [7:0]        o_host_rdata,
  output logic              o_init_busy,
  output logic              o_init_done,
  output logic              o_init_err,
  output logic [ROM_AW-1:0] o_err_idx
);

  localparam int unsigned CycW  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned PollW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [CycW-1:0]  CycLast  = CycW'(CLK_PER_US - 1);
  localparam logic [PollW-1:0] PollLast = PollW'(POLL_MAX - 1);

  localparam logic [1:0] OpWrite = 2'd0;
  localparam logic [1:0] OpPoll  = 2'd1;
  localparam logic [1:0] OpDelay = 2'd2;
  localparam logic [1:0] OpEnd   = 2'd3;

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StReq, StXfer, StFin, StCheck, StDelay,
    StHostReq, StHostXfer, StHostFin
  } state_e;

  state_e             r_state_q,      w_state_d;
  logic [ROM_AW-1:0]  r_rom_addr_q,   w_rom_addr_d;
  logic [9:0]         r_spi_addr_q,   w_spi_addr_d;
  logic [7:0]         r_spi_wdata_q,  w_spi_wdata_d;
  logic               r_spi_wr_rdn_q, w_spi_wr_rdn_d;
  logic               r_spi_en_q,     w_spi_en_d;
  logic               r_host_ack_q,   w_host_ack_d;
  logic [7:0]         r_host_rdata_q, w_host_rdata_d;
  logic               r_init_busy_q,  w_init_busy_d;
  logic               r_init_done_q,  w_init_done_d;
  logic               r_init_err_q,   w_init_err_d;
  logic [ROM_AW-1:0]  r_err_idx_q,    w_err_idx_d;
  logic [7:0]         r_rdata_q,      w_rdata_d;
  logic [PollW-1:0]   r_poll_cnt_q,   w_poll_cnt_d;
  logic [17:0]        r_us_cnt_q,     w_us_cnt_d;
  logic [CycW-1:0]    r_cyc_cnt_q,    w_cyc_cnt_d;

  logic [1:0]  w_op;
  logic [9:0]  w_addr;
  logic [7:0]  w_data;
  logic [17:0] w_dly;
  logic        w_in_xfer;

  assign w_op   = i_rom_data[19:18];
  assign w_addr = i_rom_data[17:8];
  assign w_data = i_rom_data[7:0];
  assign w_dly  = i_rom_data[17:0];

  assign w_in_xfer = (r_state_q == StReq) || (r_state_q == StXfer) ||
                     (r_state_q == StHostReq) || (r_state_q == StHostXfer);

  always_comb begin
    w_state_d      = r_state_q;
    w_rom_addr_d   = r_rom_addr_q;
    w_spi_addr_d   = r_spi_addr_q;
    w_spi_wdata_d  = r_spi_wdata_q;
    w_spi_wr_rdn_d = r_spi_wr_rdn_q;
    w_host_ack_d   = 1'b0;
    w_host_rdata_d = r_host_rdata_q;
    w_init_busy_d  = r_init_busy_q;
    w_init_done_d  = r_init_done_q;
    w_init_err_d   = r_init_err_q;
    w_err_idx_d    = r_err_idx_q;
    w_rdata_d      = r_rdata_q;
    w_poll_cnt_d   = r_poll_cnt_q;
    w_us_cnt_d     = r_us_cnt_q;
    w_cyc_cnt_d    = r_cyc_cnt_q;

    if (i_spi_rdata_en && w_in_xfer) begin
      w_rdata_d = i_spi_rdata;
    end

    case (r_state_q)
      StIdle: begin
        if (i_start) begin
          w_rom_addr_d  = '0;
          w_init_done_d = 1'b0;
          w_init_err_d  = 1'b0;
          w_poll_cnt_d  = '0;
          w_init_busy_d = 1'b1;
          w_state_d     = StFetch;
        // host_req is still high during the ack cycle; don't re-serve it.
        end else if (i_host_req && !r_init_busy_q && !r_host_ack_q) begin
          w_spi_addr_d   = i_host_addr;
          w_spi_wdata_d  = i_host_wdata;
          w_spi_wr_rdn_d = i_host_wr_rdn;
          w_state_d      = StHostReq;
        end
      end
      StFetch: w_state_d = StDecode;
      StDecode: begin
        case (w_op)
          OpWrite, OpPoll: begin
            // For POLL, the wdata field carries the mask (ignored by a read).
            w_spi_addr_d   = w_addr;
            w_spi_wdata_d  = w_data;
            w_spi_wr_rdn_d = (w_op == OpWrite);
            w_state_d      = StReq;
          end
          OpDelay: begin
            if (w_dly == '0) begin
              w_rom_addr_d = r_rom_addr_q + 1'b1;
              w_state_d    = StFetch;
            end else begin
              w_us_cnt_d  = w_dly;
              w_cyc_cnt_d = '0;
              w_state_d   = StDelay;
            end
          end
          default: begin
            w_init_done_d = 1'b1;
            w_init_busy_d = 1'b0;
            w_state_d     = StIdle;
          end
        endcase
      end
      StReq:  if (i_spi_busy)  w_state_d = StXfer;
      StXfer: if (!i_spi_busy) w_state_d = StFin;
      StFin: begin
        if (r_spi_wr_rdn_q) begin
          w_rom_addr_d = r_rom_addr_q + 1'b1;
          w_state_d    = StFetch;
        end else begin
          w_state_d = StCheck;
        end
      end
      StCheck: begin
        if ((r_rdata_q & r_spi_wdata_q) == r_spi_wdata_q) begin
          w_poll_cnt_d = '0;
          w_rom_addr_d = r_rom_addr_q + 1'b1;
          w_state_d    = StFetch;
        end else if (r_poll_cnt_q < PollLast) begin
          w_poll_cnt_d = r_poll_cnt_q + 1'b1;
          w_state_d    = StReq;
        end else begin
          w_init_err_d  = 1'b1;
          w_err_idx_d   = r_rom_addr_q;
          w_init_busy_d = 1'b0;
          w_state_d     = StIdle;
        end
      end
      StDelay: begin
        if (r_cyc_cnt_q == CycLast) begin
          w_cyc_cnt_d = '0;
          w_us_cnt_d  = r_us_cnt_q - 18'd1;
          if (r_us_cnt_q == 18'd1) begin
            w_rom_addr_d = r_rom_addr_q + 1'b1;
            w_state_d    = StFetch;
          end
        end else begin
          w_cyc_cnt_d = r_cyc_cnt_q + 1'b1;
        end
      end
      StHostReq:  if (i_spi_busy)  w_state_d = StHostXfer;
      StHostXfer: if (!i_spi_busy) w_state_d = StHostFin;
      StHostFin: begin
        w_host_ack_d = 1'b1;
        if (!r_spi_wr_rdn_q) begin
          w_host_rdata_d = r_rdata_q;
        end
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    // Request strobe is high exactly while the FSM sits in a request state.
    w_spi_en_d = (w_state_d == StReq) || (w_state_d == StHostReq);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state_q      <= StIdle;
      r_rom_addr_q   <= '0;
      r_spi_addr_q   <= '0;
      r_spi_wdata_q  <= '0;
      r_spi_wr_rdn_q <= 1'b1;
      r_spi_en_q     <= 1'b0;
      r_host_ack_q   <= 1'b0;
      r_host_rdata_q <= '0;
      r_init_busy_q  <= 1'b0;
      r_init_done_q  <= 1'b0;
      r_init_err_q   <= 1'b0;
      r_err_idx_q    <= '0;
      r_rdata_q      <= '0;
      r_poll_cnt_q   <= '0;
      r_us_cnt_q     <= '0;
      r_cyc_cnt_q    <= '0;
    end else begin
      r_state_q      <= w_state_d;
      r_rom_addr_q   <= w_rom_addr_d;
      r_spi_addr_q   <= w_spi_addr_d;
      r_spi_wdata_q  <= w_spi_wdata_d;
      r_spi_wr_rdn_q <= w_spi_wr_rdn_d;
      r_spi_en_q     <= w_spi_en_d;
      r_host_ack_q   <= w_host_ack_d;
      r_host_rdata_q <= w_host_rdata_d;
      r_init_busy_q  <= w_init_busy_d;
      r_init_done_q  <= w_init_done_d;
      r_init_err_q   <= w_init_err_d;
      r_err_idx_q    <= w_err_idx_d;
      r_rdata_q      <= w_rdata_d;
      r_poll_cnt_q   <= w_poll_cnt_d;
      r_us_cnt_q     <= w_us_cnt_d;
      r_cyc_cnt_q    <= w_cyc_cnt_d;
    end
  end

  assign o_rom_addr   = r_rom_addr_q;
  assign o_spi_addr   = r_spi_addr_q;
  assign o_spi_wdata  = r_spi_wdata_q;
  assign o_spi_wr_rdn = r_spi_wr_rdn_q;
  assign o_spi_en     = r_spi_en_q;
  assign o_host_ack   = r_host_ack_q;
  assign o_host_rdata = r_host_rdata_q;
  assign o_init_busy  = r_init_busy_q;
  assign o_init_done  = r_init_done_q;
  assign o_init_err   = r_init_err_q;
  assign o_err_idx    = r_err_idx_q;

endmodule

// File: tb/tb_ad9361_cfg_seq.sv
// Testbench for ad9361_cfg_seq: a registered table ROM, a behavioural SPI
// driver that checks each request against a queue of expected transfers, and
// one task per scenario.
module tb_ad9361_cfg_seq;

  localparam int unsigned ROM_AW     = 4;
  localparam int unsigned CLK_PER_US = 20;
  localparam int unsigned POLL_MAX   = 4;
  localparam int          DRV_LEN    = 6;

  localparam logic [1:0] OP_WR   = 2'd0;
  localparam logic [1:0] OP_POLL = 2'd1;
  localparam logic [1:0] OP_DLY  = 2'd2;
  localparam logic [1:0] OP_END  = 2'd3;

  typedef struct packed {
    logic       wr;
    logic [9:0] addr;
    logic [7:0] data;
  } xfer_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ROM_AW-1:0] rom_addr;
  logic [19:0]       rom_data = '0;
  logic [9:0]        spi_addr;
  logic [7:0]        spi_wdata;
  logic              spi_wr_rdn;
  logic              spi_en;
  logic              drv_busy = 1'b0;
  logic [7:0]        spi_rdata = '0;
  logic              spi_rdata_en = 1'b0;
  logic              host_req = 1'b0;
  logic              host_wr_rdn = 1'b0;
  logic [9:0]        host_addr = '0;
  logic [7:0]        host_wdata = '0;
  logic              host_ack;
  logic [7:0]        host_rdata;
  logic              init_busy;
  logic              init_done;
  logic              init_err;
  logic [ROM_AW-1:0] err_idx;

  always #5 clk = ~clk;

  ad9361_cfg_seq #(
    .ROM_AW     (ROM_AW),
    .CLK_PER_US (CLK_PER_US),
    .POLL_MAX   (POLL_MAX)
  ) u_dut (
    .i_sys_clk      (clk),
    .i_sys_rst      (rst),
    .i_start        (start),
    .o_rom_addr     (rom_addr),
    .i_rom_data     (rom_data),
    .o_spi_addr     (spi_addr),
    .o_spi_wdata    (spi_wdata),
    .o_spi_wr_rdn   (spi_wr_rdn),
    .o_spi_en       (spi_en),
    .i_spi_busy     (drv_busy),
    .i_spi_rdata    (spi_rdata),
    .i_spi_rdata_en (spi_rdata_en),
    .i_host_req     (host_req),
    .i_host_wr_rdn  (host_wr_rdn),
    .i_host_addr    (host_addr),
    .i_host_wdata   (host_wdata),
    .o_host_ack     (host_ack),
    .o_host_rdata   (host_rdata),
    .o_init_busy    (init_busy),
    .o_init_done    (init_done),
    .o_init_err     (init_err),
    .o_err_idx      (err_idx)
  );

  logic [19:0] rom [16];
  always @(posedge clk) rom_data <= rom[rom_addr];

  xfer_t      exp_q[$];
  logic [7:0] rsp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_neg = 0;
  int ack_cnt = 0;
  int ack_n = 0;
  int fall_n = 0;
  int drv_cnt = 0;
  xfer_t cap;
  xfer_t exp_x;
  bit hold_bad = 1'b0;
  bit hold_ign = 1'b0;

  // SPI driver model, evaluated on the falling edge.
  always @(negedge clk) begin
    n_neg++;
    if (host_ack) begin
      ack_cnt++;
      ack_n = n_neg;
    end
    spi_rdata_en = 1'b0;
    if (!drv_busy) begin
      if (spi_en && !rst) begin
        cap = {spi_wr_rdn, spi_addr, spi_wdata};
        drv_busy = 1'b1;
        drv_cnt  = DRV_LEN;
        hold_bad = 1'b0;
        hold_ign = 1'b0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL spi_unexpected: got wr=%0d addr=%h data=%h, required no transfer",
                   cap.wr, cap.addr, cap.data);
        end else begin
          exp_x = exp_q.pop_front();
          if (cap.wr !== exp_x.wr || cap.addr !== exp_x.addr ||
              (exp_x.wr && cap.data !== exp_x.data)) begin
            n_bad++;
            $display("FAIL spi_xfer: got wr=%0d addr=%h data=%h, required wr=%0d addr=%h data=%h",
                     cap.wr, cap.addr, cap.data, exp_x.wr, exp_x.addr, exp_x.data);
          end
        end
      end
    end else begin
      if (rst) hold_ign = 1'b1;
      else if ({spi_wr_rdn, spi_addr, spi_wdata} !== cap) hold_bad = 1'b1;
      if (drv_cnt == 2 && !cap.wr) begin
        spi_rdata    = (rsp_q.size() != 0) ? rsp_q.pop_front() : 8'h00;
        spi_rdata_en = 1'b1;
      end
      if (drv_cnt == 0) begin
        drv_busy = 1'b0;
        fall_n   = n_neg;
        if (!hold_ign) begin
          n_cmp++;
          if (hold_bad) begin
            n_bad++;
            $display("FAIL spi_hold: fields changed during transfer to %h, required stable",
                     cap.addr);
          end
        end
      end else begin
        drv_cnt--;
      end
    end
  end

  function automatic logic [19:0] ent(logic [1:0] op, logic [9:0] a, logic [7:0] d);
    return {op, a, d};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = ent(OP_END, 10'h0, 8'h0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit to);
    int n = 0;
    while (init_busy && n < max) begin
      tick();
      n++;
    end
    to = init_busy;
  endtask

  task automatic wait_ack(input int max, output bit to);
    int n = 0;
    while (!host_ack && n < max) begin
      tick();
      n++;
    end
    to = !host_ack;
  endtask

  task automatic test_reset();
    logic [ROM_AW+30:0] got;
    rst = 1'b1;
    repeat (3) tick();
    got = {rom_addr, spi_addr, spi_wdata, spi_wr_rdn, spi_en, host_ack, host_rdata,
           init_busy, init_done, init_err, err_idx};
    n_cmp++;
    if (got !== {{ROM_AW{1'b0}}, 10'h0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0,
                 {ROM_AW{1'b0}}}) begin
      n_bad++;
      $display("FAIL reset_state: got %h, required all zero except spi_wr_rdn=1", got);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (spi_en !== 1'b0 || init_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got spi_en=%b init_busy=%b, required 0 0", spi_en, init_busy);
    end
  endtask

  task automatic test_write_seq();
    bit to;
    int a0 = ack_cnt;
    clear_rom();
    rom[0] = ent(OP_WR, 10'h3DF, 8'h01);
    rom[1] = ent(OP_WR, 10'h015, 8'h04);
    exp_q.push_back({1'b1, 10'h3DF, 8'h01});
    exp_q.push_back({1'b1, 10'h015, 8'h04});
    pulse_start();
    wait_idle(300, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL write_seq_timeout: init_busy stuck at 1, required 0"); end
    n_cmp++;
    if (init_done !== 1'b1 || init_err !== 1'b0) begin
      n_bad++;
      $display("FAIL write_seq_status: got done=%b err=%b, required 1 0", init_done, init_err);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL write_seq_count: %0d transfers missing, required 0", exp_q.size());
    end
    n_cmp++;
    if (ack_cnt != a0) begin
      n_bad++;
      $display("FAIL write_seq_ack: got %0d host_ack pulses, required 0", ack_cnt - a0);
    end
  endtask

  task automatic test_host();
    bit to;
    int a0 = ack_cnt;
    exp_q.push_back({1'b0, 10'h037, 8'h00});
    rsp_q.push_back(8'hA5);
    host_wr_rdn = 1'b0;
    host_addr   = 10'h037;
    host_wdata  = 8'h00;
    host_req    = 1'b1;
    wait_ack(200, to);
    host_req = 1'b0;
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL host_read_timeout: no host_ack, required one"); end
    n_cmp++;
    if (host_rdata !== 8'hA5) begin
      n_bad++;
      $display("FAIL host_read_data: got %h, required a5", host_rdata);
    end
    n_cmp++;
    if (ack_n - fall_n != 2) begin
      n_bad++;
      $display("FAIL host_ack_latency: got %0d cycles after busy fall, required 2",
               ack_n - fall_n);
    end
    repeat (4) tick();
    n_cmp++;
    if (ack_cnt - a0 != 1) begin
      n_bad++;
      $display("FAIL host_read_ack_once: got %0d pulses, required 1", ack_cnt - a0);
    end
    a0 = ack_cnt;
    exp_q.push_back({1'b1, 10'h002, 8'h5E});
    host_wr_rdn = 1'b1;
    host_addr   = 10'h002;
    host_wdata  = 8'h5E;
    host_req    = 1'b1;
    wait_ack(200, to);
    host_req = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (to || ack_cnt - a0 != 1) begin
      n_bad++;
      $display("FAIL host_write_ack: got %0d pulses, required 1", ack_cnt - a0);
    end
    n_cmp++;
    if (exp_q.size() != 0 || host_rdata !== 8'hA5) begin
      n_bad++;
      $display("FAIL host_write_done: got %0d pending, rdata=%h, required 0 pending, rdata=a5",
               exp_q.size(), host_rdata);
    end
  endtask

  task automatic test_poll_ok();
    bit to;
    clear_rom();
    rom[0] = ent(OP_POLL, 10'h244, 8'h80);
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 10'h244, 8'h80});
    rsp_q.push_back(8'h00);
    rsp_q.push_back(8'h00);
    rsp_q.push_back(8'h81);
    pulse_start();
    wait_idle(500, to);
    repeat (20) tick();
    n_cmp++;
    if (to || init_done !== 1'b1 || init_err !== 1'b0) begin
      n_bad++;
      $display("FAIL poll_ok_status: got done=%b err=%b, required 1 0", init_done, init_err);
    end
    n_cmp++;
    if (exp_q.size() != 0 || rsp_q.size() != 0) begin
      n_bad++;
      $display("FAIL poll_ok_reads: %0d reads missing, required 3 reads total", exp_q.size());
    end
  endtask

  task automatic test_poll_timeout();
    bit to;
    clear_rom();
    rom[0] = ent(OP_POLL, 10'h244, 8'h80);
    for (int i = 0; i < int'(POLL_MAX); i++) exp_q.push_back({1'b0, 10'h244, 8'h80});
    pulse_start();
    wait_idle(800, to);
    repeat (30) tick();
    n_cmp++;
    if (to || init_err !== 1'b1 || init_done !== 1'b0 || init_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL poll_to_status: got err=%b done=%b busy=%b, required 1 0 0",
               init_err, init_done, init_busy);
    end
    n_cmp++;
    if (err_idx !== 4'd0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL poll_to_idx0: got idx=%0d missing=%0d, required 0 0", err_idx, exp_q.size());
    end
    clear_rom();
    rom[0] = ent(OP_WR, 10'h010, 8'h00);
    rom[1] = ent(OP_POLL, 10'h011, 8'h01);
    exp_q.push_back({1'b1, 10'h010, 8'h00});
    for (int i = 0; i < int'(POLL_MAX); i++) exp_q.push_back({1'b0, 10'h011, 8'h01});
    pulse_start();
    wait_idle(800, to);
    repeat (30) tick();
    n_cmp++;
    if (to || init_err !== 1'b1 || err_idx !== 4'd1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL poll_to_idx1: got err=%b idx=%0d missing=%0d, required 1 1 0",
               init_err, err_idx, exp_q.size());
    end
  endtask

  task automatic test_host_after_err();
    bit to;
    exp_q.push_back({1'b1, 10'h0AA, 8'h11});
    host_wr_rdn = 1'b1;
    host_addr   = 10'h0AA;
    host_wdata  = 8'h11;
    host_req    = 1'b1;
    wait_ack(200, to);
    host_req = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (to || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL host_after_err: got timeout=%b missing=%0d, required 0 0", to, exp_q.size());
    end
  endtask

  task automatic test_delay();
    int us_tab[3] = '{5, 0, 256};
    for (int k = 0; k < 3; k++) begin
      int n;
      int cnt = 0;
      logic [17:0] v;
      n = us_tab[k];
      v = 18'(n);
      clear_rom();
      rom[0] = ent(OP_DLY, v[17:8], v[7:0]);
      pulse_start();
      while (init_busy && cnt < 10000) begin
        cnt++;
        tick();
      end
      n_cmp++;
      if (cnt != 4 + n * int'(CLK_PER_US) || init_done !== 1'b1) begin
        n_bad++;
        $display("FAIL delay_%0dus: got %0d busy cycles done=%b, required %0d done=1",
                 n, cnt, init_done, 4 + n * int'(CLK_PER_US));
      end
    end
  endtask

  task automatic test_start_host_collision();
    bit to;
    clear_rom();
    rom[0] = ent(OP_WR, 10'h3DF, 8'h01);
    exp_q.push_back({1'b1, 10'h3DF, 8'h01});
    exp_q.push_back({1'b0, 10'h037, 8'h00});
    rsp_q.push_back(8'h3C);
    host_wr_rdn = 1'b0;
    host_addr   = 10'h037;
    host_req    = 1'b1;
    pulse_start();
    wait_ack(400, to);
    n_cmp++;
    if (to || init_done !== 1'b1 || host_rdata !== 8'h3C) begin
      n_bad++;
      $display("FAIL collision: got timeout=%b done=%b rdata=%h, required 0 1 3c",
               to, init_done, host_rdata);
    end
    host_req = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL collision_order: %0d transfers missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_rom();
    rom[0] = ent(OP_WR, 10'h3DF, 8'h01);
    exp_q.push_back({1'b1, 10'h3DF, 8'h01});
    pulse_start();
    while (!drv_busy && n < 50) begin
      tick();
      n++;
    end
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (spi_en !== 1'b0 || init_busy !== 1'b0 || init_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got spi_en=%b busy=%b done=%b, required 0 0 0",
               spi_en, init_busy, init_done);
    end
    rst = 1'b0;
    n = 0;
    while (drv_busy && n < 50) begin
      tick();
      n++;
    end
    repeat (5) tick();
    n_cmp++;
    if (exp_q.size() != 0 || init_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_after: got missing=%0d busy=%b, required 0 0",
               exp_q.size(), init_busy);
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_write_seq();
    test_host();
    test_poll_ok();
    test_poll_timeout();
    test_host_after_err();
    test_delay();
    test_start_host_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
